// File: rtl/i2c_target.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detection, byte receive
// strobe and byte load interface for reads. Open-drain SDA, never stretches SCL.
module i2c_target #(
    parameter logic [6:0] kADDR        = 7'h42,
    parameter int         kSYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } state_t;

    logic [kSYNC_STAGES-1:0] scl_sync_reg;
    logic [kSYNC_STAGES-1:0] sda_sync_reg;
    logic                    scl_prev_reg;
    logic                    sda_prev_reg;

    state_t      state_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt_reg;
    logic        rw_reg;
    logic        phase_reg;
    logic        sda_low_reg;

    logic        scl_s;
    logic        sda_s;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;
    logic [7:0]  shift_in;

    // Synchronizers preset high so reset never looks like a bus edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[kSYNC_STAGES-2:0], SCL};
            sda_sync_reg <= {sda_sync_reg[kSYNC_STAGES-2:0], SDA};
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    assign scl_s     = scl_sync_reg[kSYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[kSYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;
    assign start_det = scl_s & scl_prev_reg & ~sda_s & sda_prev_reg;
    assign stop_det  = scl_s & scl_prev_reg & sda_s & ~sda_prev_reg;
    assign shift_in  = {shift_reg[6:0], sda_s};

    assign SDA = sda_low_reg ? 1'b0 : 1'bz;

    // phase_reg marks the second half of a two-step state: ACK already driven,
    // 8th bit already clocked, or initiator ACK already seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= 8'h00;
            bit_cnt_reg <= 3'd0;
            rw_reg      <= 1'b0;
            phase_reg   <= 1'b0;
            sda_low_reg <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_load     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            if (stop_det) begin
                state_reg   <= IDLE;
                sda_low_reg <= 1'b0;
                phase_reg   <= 1'b0;
                busy        <= 1'b0;
            end else if (start_det) begin
                state_reg   <= ADDR;
                sda_low_reg <= 1'b0;
                phase_reg   <= 1'b0;
                bit_cnt_reg <= 3'd0;
            end else begin
                case (state_reg)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg   <= shift_in;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                if (shift_in[7:1] == kADDR) begin
                                    state_reg <= ADDR_ACK;
                                    rw_reg    <= shift_in[0];
                                    busy      <= 1'b1;
                                end else begin
                                    state_reg <= WAIT_STOP;
                                    busy      <= 1'b0;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_reg) begin
                                sda_low_reg <= 1'b1;
                                phase_reg   <= 1'b1;
                            end else begin
                                phase_reg <= 1'b0;
                                if (rw_reg) begin
                                    tx_load     <= 1'b1;
                                    shift_reg   <= tx_data;
                                    sda_low_reg <= ~tx_data[7];
                                    state_reg   <= READ;
                                end else begin
                                    sda_low_reg <= 1'b0;
                                    state_reg   <= WRITE;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shift_reg   <= shift_in;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7)
                                phase_reg <= 1'b1;
                        end else if (scl_fall && phase_reg) begin
                            rx_data     <= shift_reg;
                            rx_valid    <= 1'b1;
                            sda_low_reg <= 1'b1;
                            phase_reg   <= 1'b0;
                            state_reg   <= WRITE_ACK;
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            sda_low_reg <= 1'b0;
                            state_reg   <= WRITE;
                        end
                    end
                    READ: begin
                        // The bit on the bus is always shift_reg[7]; advance after each rise.
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], 1'b0};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7)
                                phase_reg <= 1'b1;
                        end else if (scl_fall) begin
                            if (phase_reg) begin
                                sda_low_reg <= 1'b0;
                                phase_reg   <= 1'b0;
                                state_reg   <= READ_ACK;
                            end else begin
                                sda_low_reg <= ~shift_reg[7];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state_reg <= WAIT_STOP;
                                busy      <= 1'b0;
                            end else begin
                                phase_reg <= 1'b1;
                            end
                        end else if (scl_fall && phase_reg) begin
                            phase_reg   <= 1'b0;
                            tx_load     <= 1'b1;
                            shift_reg   <= tx_data;
                            sda_low_reg <= ~tx_data[7];
                            state_reg   <= READ;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a behavioural I2C initiator drives randomized write/read
// transactions and compares the target's responses with expectations from the bus rules.
module tb_i2c_target;

    localparam int Q = 8;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       busy;
    wire        SDA;

    pullup (SDA);
    assign SDA = sda_m_low ? 1'b0 : 1'bz;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_q[$];
    int         tx_cnt = 0;
    int         viol   = 0;
    logic       rx_prev = 1'b0;
    logic       tx_prev = 1'b0;

    i2c_target dut (
        .clk      (clk),
        .rst      (rst),
        .SCL      (scl),
        .SDA      (SDA),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_load) tx_cnt++;
        if (rx_valid && tx_load) viol++;
        if ((rx_valid && rx_prev) || (tx_load && tx_prev)) viol++;
        rx_prev = rx_valid;
        tx_prev = tx_load;
    end

    task automatic q_wait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m_low = 1'b1; q_wait();
        scl = 1'b0;       q_wait();
    endtask

    task automatic bus_rstart();
        sda_m_low = 1'b0; q_wait();
        scl = 1'b1;       q_wait();
        bus_start();
    endtask

    task automatic bus_stop();
        sda_m_low = 1'b1; q_wait();
        scl = 1'b1;       q_wait();
        sda_m_low = 1'b0; q_wait();
    endtask

    task automatic bit_wr(input logic b);
        sda_m_low = ~b; q_wait();
        scl = 1'b1;     q_wait(); q_wait();
        scl = 1'b0;     q_wait();
    endtask

    task automatic bit_rd(output logic b);
        sda_m_low = 1'b0; q_wait();
        scl = 1'b1;       q_wait();
        b = SDA;          q_wait();
        scl = 1'b0;       q_wait();
    endtask

    task automatic byte_wr(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) bit_wr(d[i]);
        bit_rd(ack_n);
    endtask

    task automatic bits_rd8(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_rd(b);
            d[i] = b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (SDA !== 1'b1) $display("FAIL reset_sda: got %b expected 1", SDA); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else n_pass++;
        n_checks++; if (tx_load !== 1'b0) $display("FAIL reset_tx_load: got %b expected 0", tx_load); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_write();
        for (int t = 0; t < 4; t++) begin
            logic [7:0] data[$];
            logic       ack_n;
            int         base = rx_q.size();
            int         n    = (t == 0) ? 1 : int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) data.push_back((t == 0) ? 8'hA5 : 8'($urandom));
            bus_start();
            byte_wr({7'h42, 1'b0}, ack_n);
            n_checks++; if (ack_n !== 1'b0) $display("FAIL write_addr_ack t%0d: got %b expected 0", t, ack_n); else n_pass++;
            n_checks++; if (busy !== 1'b1) $display("FAIL write_busy t%0d: got %b expected 1", t, busy); else n_pass++;
            for (int k = 0; k < n; k++) begin
                byte_wr(data[k], ack_n);
                n_checks++; if (ack_n !== 1'b0) $display("FAIL write_data_ack t%0d b%0d: got %b expected 0", t, k, ack_n); else n_pass++;
            end
            bus_stop();
            n_checks++; if (busy !== 1'b0) $display("FAIL write_busy_stop t%0d: got %b expected 0", t, busy); else n_pass++;
            n_checks++; if (rx_q.size() - base != n) $display("FAIL write_rx_count t%0d: got %0d expected %0d", t, rx_q.size() - base, n); else n_pass++;
            for (int k = 0; k < n && base + k < rx_q.size(); k++) begin
                n_checks++; if (rx_q[base + k] !== data[k]) $display("FAIL write_rx_byte t%0d b%0d: got %h expected %h", t, k, rx_q[base + k], data[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_wrong_addr();
        for (int t = 0; t < 3; t++) begin
            logic [6:0] a = (t == 0) ? 7'h43 : 7'($urandom_range(0, 127));
            logic [7:0] d = (t == 0) ? 8'hFF : 8'($urandom);
            logic       ack_n;
            int         base_rx = rx_q.size();
            int         base_tx = tx_cnt;
            if (a == 7'h42) a = 7'h41;
            bus_start();
            byte_wr({a, 1'b0}, ack_n);
            n_checks++; if (ack_n !== 1'b1) $display("FAIL wrong_addr_ack a%h: got %b expected 1", a, ack_n); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL wrong_addr_busy a%h: got %b expected 0", a, busy); else n_pass++;
            byte_wr(d, ack_n);
            n_checks++; if (ack_n !== 1'b1) $display("FAIL wrong_addr_data_ack a%h: got %b expected 1", a, ack_n); else n_pass++;
            bus_stop();
            n_checks++; if (rx_q.size() != base_rx || tx_cnt != base_tx) $display("FAIL wrong_addr_strobes a%h: got rx %0d tx %0d expected 0 0", a, rx_q.size() - base_rx, tx_cnt - base_tx); else n_pass++;
        end
    endtask

    task automatic test_read();
        for (int t = 0; t < 3; t++) begin
            logic [7:0] data[$];
            logic [7:0] got;
            logic       ack_n;
            int         base_tx = tx_cnt;
            int         base_rx = rx_q.size();
            int         n = (t == 0) ? 2 : int'($urandom_range(1, 4));
            if (t == 0) begin
                data.push_back(8'h3C);
                data.push_back(8'hF0);
            end else begin
                for (int k = 0; k < n; k++) data.push_back(8'($urandom));
            end
            tx_data = data[0];
            bus_start();
            byte_wr({7'h42, 1'b1}, ack_n);
            n_checks++; if (ack_n !== 1'b0) $display("FAIL read_addr_ack t%0d: got %b expected 0", t, ack_n); else n_pass++;
            for (int k = 0; k < n; k++) begin
                bits_rd8(got);
                n_checks++; if (got !== data[k]) $display("FAIL read_byte t%0d b%0d: got %h expected %h", t, k, got, data[k]); else n_pass++;
                tx_data = (k + 1 < n) ? data[k + 1] : 8'($urandom);
                bit_wr(k == n - 1);
            end
            n_checks++; if (busy !== 1'b0) $display("FAIL read_busy_nack t%0d: got %b expected 0", t, busy); else n_pass++;
            bus_stop();
            n_checks++; if (tx_cnt - base_tx != n) $display("FAIL read_tx_load_count t%0d: got %0d expected %0d", t, tx_cnt - base_tx, n); else n_pass++;
            n_checks++; if (rx_q.size() != base_rx) $display("FAIL read_no_rx t%0d: got %0d expected 0", t, rx_q.size() - base_rx); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wd = 8'h11;
        logic [7:0] rd = 8'h5A;
        for (int t = 0; t < 2; t++) begin
            logic [7:0] got;
            logic       ack_n;
            int         base_rx = rx_q.size();
            int         base_tx = tx_cnt;
            if (t > 0) begin
                wd = 8'($urandom);
                rd = 8'($urandom);
            end
            tx_data = rd;
            bus_start();
            byte_wr({7'h42, 1'b0}, ack_n);
            byte_wr(wd, ack_n);
            n_checks++; if (ack_n !== 1'b0) $display("FAIL rs_write_ack t%0d: got %b expected 0", t, ack_n); else n_pass++;
            bus_rstart();
            n_checks++; if (busy !== 1'b1) $display("FAIL rs_busy_held t%0d: got %b expected 1", t, busy); else n_pass++;
            byte_wr({7'h42, 1'b1}, ack_n);
            n_checks++; if (ack_n !== 1'b0) $display("FAIL rs_read_addr_ack t%0d: got %b expected 0", t, ack_n); else n_pass++;
            bits_rd8(got);
            bit_wr(1'b1);
            bus_stop();
            n_checks++; if (got !== rd) $display("FAIL rs_read_byte t%0d: got %h expected %h", t, got, rd); else n_pass++;
            n_checks++; if (rx_q.size() - base_rx != 1) $display("FAIL rs_rx_count t%0d: got %0d expected 1", t, rx_q.size() - base_rx); else n_pass++;
            if (rx_q.size() > base_rx) begin
                n_checks++; if (rx_q[base_rx] !== wd) $display("FAIL rs_rx_byte t%0d: got %h expected %h", t, rx_q[base_rx], wd); else n_pass++;
            end
            n_checks++; if (tx_cnt - base_tx != 1) $display("FAIL rs_tx_load_count t%0d: got %0d expected 1", t, tx_cnt - base_tx); else n_pass++;
        end
    endtask

    task automatic test_partial_stop();
        logic       ack_n;
        logic [3:0] nib = 4'($urandom);
        int         base_rx = rx_q.size();
        bus_start();
        byte_wr({7'h42, 1'b0}, ack_n);
        for (int i = 3; i >= 0; i--) bit_wr(nib[i]);
        bus_stop();
        n_checks++; if (rx_q.size() != base_rx) $display("FAIL partial_no_rx: got %0d expected 0", rx_q.size() - base_rx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL partial_busy: got %b expected 0", busy); else n_pass++;
        bus_start();
        byte_wr({7'h42, 1'b0}, ack_n);
        byte_wr(8'h22, ack_n);
        bus_stop();
        n_checks++; if (rx_q.size() - base_rx != 1) $display("FAIL partial_next_count: got %0d expected 1", rx_q.size() - base_rx); else n_pass++;
        n_checks++; if (rx_data !== 8'h22) $display("FAIL partial_next_rx_data: got %h expected 22", rx_data); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic       ack_n;
        logic [7:0] d = 8'($urandom);
        int         base_rx;
        bus_start();
        for (int i = 7; i >= 0; i--) bit_wr(i == 0 ? 1'b0 : ((8'h84 >> i) & 8'h01) != 0);
        sda_m_low = 1'b0;
        @(negedge clk);
        n_checks++; if (SDA !== 1'b0) $display("FAIL mid_ack_driven: got %b expected 0", SDA); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (SDA !== 1'b1) $display("FAIL mid_sda_released: got %b expected 1", SDA); else n_pass++;
        n_checks++; if (rx_data !== 8'h00 || busy !== 1'b0 || rx_valid !== 1'b0 || tx_load !== 1'b0)
            $display("FAIL mid_outputs: got rx_data %h busy %b rx_valid %b tx_load %b expected 00 0 0 0", rx_data, busy, rx_valid, tx_load);
        else n_pass++;
        q_wait();
        scl = 1'b1; q_wait(); q_wait();
        scl = 1'b0; q_wait();
        byte_wr({7'h42, 1'b0}, ack_n);
        n_checks++; if (ack_n !== 1'b1) $display("FAIL mid_no_response: got %b expected 1", ack_n); else n_pass++;
        bus_stop();
        base_rx = rx_q.size();
        bus_start();
        byte_wr({7'h42, 1'b0}, ack_n);
        n_checks++; if (ack_n !== 1'b0) $display("FAIL mid_reacquire_ack: got %b expected 0", ack_n); else n_pass++;
        byte_wr(d, ack_n);
        bus_stop();
        n_checks++; if (rx_q.size() - base_rx != 1 || rx_data !== d) $display("FAIL mid_reacquire_rx: got %0d bytes %h expected 1 bytes %h", rx_q.size() - base_rx, rx_data, d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read();
        test_back_to_back();
        test_partial_stop();
        test_reset_mid();
        n_checks++; if (viol != 0) $display("FAIL strobe_rules: got %0d violations expected 0", viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Single-address I2C target (slave) responding to the 10 kHz I2C initiator on the same SCL/SDA bus.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address; receives write bytes to a byte strobe interface; serves read bytes from a byte load interface.
- Open-drain: drives SDA low or releases it; never drives SCL (no clock stretching).

Parameters:
- kADDR, 7'h42, 7-bit target address.
- kSYNC_STAGES, 2, flip-flop synchronizer depth on SCL and SDA (≥2).

Ports:
- clk  input  1  system clock; must be ≥ 16× SCL frequency.
- rst  input  1  synchronous active-high reset.
- SCL  input  1  I2C clock from bus.
- SDA  inout  1  I2C data; driven 0 or 'z' only.
- rx_data  output  8  last received write byte.
- rx_valid  output  1  one-cycle pulse; rx_data updated this cycle.
- tx_data  input  8  next read byte; sampled on tx_load cycle.
- tx_load  output  1  one-cycle pulse; tx_data captured this cycle.
- busy  output  1  high from address match until STOP / NACK end.

Behaviour:
- Reset values: SDA released ('z'), rx_data=0, rx_valid=0, tx_load=0, busy=0, state IDLE, synchronizers preset to 1.
- SCL and SDA pass through kSYNC_STAGES sync FFs plus one edge-detect FF. All events are decided on synchronized values.
- Event latency from a pin edge is kSYNC_STAGES+1 cycles.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- SDA is sampled on SCL rising edge. The SDA drive changes only on SCL falling edge.
- Bits are MSB first. A 3-bit counter counts bits 0..7 within each byte.
- States:
  - IDLE: wait for START → ADDR.
  - ADDR: shift 8 bits (7 address + R/W). After the 8th rising edge:
    - match → ADDR_ACK, busy=1.
    - mismatch → WAIT_STOP, SDA never driven.
  - ADDR_ACK: drive SDA=0 from the falling edge after bit 8 until the next falling edge.
    - R/W=0 → WRITE.
    - R/W=1 → READ. On that same falling edge, pulse tx_load, capture tx_data into the shift register, and drive bit 7.
  - WRITE: shift 8 bits. On the falling edge after bit 8: rx_data ← shift register, rx_valid pulse, drive ACK → WRITE_ACK. All written bytes are ACKed.
  - WRITE_ACK: release SDA on the next falling edge → WRITE.
  - READ: on each falling edge, drive the current bit (0 → drive low, 1 → release). After the 8th bit's falling edge, release SDA → READ_ACK.
  - READ_ACK: sample SDA on rising edge.
    - 0 (ACK): on the next falling edge pulse tx_load, load the new byte, drive bit 7 → READ.
    - 1 (NACK): → WAIT_STOP, busy=0, SDA released.
  - WAIT_STOP: ignore bits; wait for START/STOP.
- START in any non-IDLE state (repeated START): SDA released, bit counter cleared → ADDR. busy stays at its value until the address resolves.
- STOP in any state: SDA released, busy=0 → IDLE. A partial byte is discarded with no rx_valid.
- rst asserted mid-transfer: SDA released on the next clk edge, all state cleared. The bus is re-acquired only at the next START.
- rx_valid and tx_load are never asserted in the same cycle and never for more than one cycle.

Test Plan:
- Reset, then START, 0x84 (0x42 W), data 0xA5, STOP → SDA low during both 9th clocks; rx_data=0xA5; exactly one rx_valid pulse; busy 1→0 at STOP.
- START, 0x86 (0x43 W), 0xFF, STOP → SDA never driven low; no rx_valid; busy stays 0.
- START, 0x85, tx_data=0x3C, initiator ACK, tx_data=0xF0, initiator NACK, STOP → SDA bits 0011_1100 then 1111_0000; tx_load pulses exactly twice; busy 0 after NACK.
- START, 0x84, 0x11, repeated START, 0x85, tx_data=0x5A, NACK, STOP → rx_data=0x11 with one rx_valid; read byte 0x5A on SDA; no STOP needed between.
- STOP after 4 bits of a write byte → state IDLE; no rx_valid; a following full write of 0x22 yields rx_data=0x22.
- Assert rst for one cycle while target drives the address ACK → SDA 'z' next cycle; outputs at reset values; no response until the next START.
